// File: rtl/traffic_light_monitor_if.sv
// Bundle between the traffic-light controller side (master) and the
// monitor (slave): the sampled light bus, the error-clear strobe and all
// decoded status coming back from the monitor.
interface traffic_light_monitor_if #(
  parameter int CNT_W = 8
);
  logic [2:0]       lights;
  logic             clr_err;
  logic [1:0]       phase;
  logic             phase_change;
  logic [CNT_W-1:0] dwell_cnt;
  logic [15:0]      cycle_cnt;
  logic             err_illegal;
  logic             err_order;
  logic             err_short;
  logic             err_timeout;

  modport master (
    output lights, clr_err,
    input  phase, phase_change, dwell_cnt, cycle_cnt,
    input  err_illegal, err_order, err_short, err_timeout
  );

  modport slave (
    input  lights, clr_err,
    output phase, phase_change, dwell_cnt, cycle_cnt,
    output err_illegal, err_order, err_short, err_timeout
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic-light controller. Decodes the one-hot
// light bus into a phase, times each phase, checks order and dwell limits,
// keeps sticky error flags and counts completed R->G->Y->R cycles.
module traffic_light_monitor #(
  parameter int CNT_W      = 8,
  parameter int MIN_RED    = 4,
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_DWELL  = 200
) (
  input  logic                  clk,
  input  logic                  rst,
  traffic_light_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RED    = 2'b01,
    ST_GREEN  = 2'b10,
    ST_YELLOW = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DWELL_MAX  = CNT_W'(MAX_DWELL);
  localparam logic [CNT_W-1:0] MIN_R      = CNT_W'(MIN_RED);
  localparam logic [CNT_W-1:0] MIN_G      = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MIN_Y      = CNT_W'(MIN_YELLOW);

  // Error vector bit positions
  localparam int E_TIMEOUT = 0;
  localparam int E_SHORT   = 1;
  localparam int E_ORDER   = 2;
  localparam int E_ILLEGAL = 3;

  state_t           state_reg, state_next;
  state_t           pat_state, succ_state;
  logic             pat_legal;
  logic [CNT_W-1:0] dwell_reg, dwell_next, dwell_inc, min_dwell;
  logic             pc_reg, pc_next;
  logic             partial_reg, partial_next;
  logic [15:0]      cycle_reg, cycle_next;
  logic [3:0]       err_reg, err_next, err_set;

  assign dwell_inc = dwell_reg + 1'b1;

  // Decode the light bus; anything not exactly one-hot is illegal
  always_comb begin
    pat_legal = 1'b1;
    pat_state = ST_IDLE;
    case (mon.lights)
      3'b100:  pat_state = ST_RED;
      3'b001:  pat_state = ST_GREEN;
      3'b010:  pat_state = ST_YELLOW;
      default: pat_legal = 1'b0;
    endcase
  end

  // Per-phase minimum dwell and the only legal successor phase
  always_comb begin
    min_dwell  = '0;
    succ_state = ST_IDLE;
    case (state_reg)
      ST_RED:    begin min_dwell = MIN_R; succ_state = ST_GREEN;  end
      ST_GREEN:  begin min_dwell = MIN_G; succ_state = ST_YELLOW; end
      ST_YELLOW: begin min_dwell = MIN_Y; succ_state = ST_RED;    end
      default:   begin min_dwell = '0;    succ_state = ST_IDLE;   end
    endcase
  end

  // Next-state, dwell timing, cycle counting and error detection
  always_comb begin
    state_next   = state_reg;
    dwell_next   = dwell_reg;
    pc_next      = 1'b0;
    partial_next = partial_reg;
    cycle_next   = cycle_reg;
    err_set      = '0;
    if (!pat_legal) begin
      // Illegal pattern drops to IDLE; no short/order judgement is possible
      state_next          = ST_IDLE;
      dwell_next          = '0;
      partial_next        = 1'b0;
      pc_next             = (state_reg != ST_IDLE);
      err_set[E_ILLEGAL]  = 1'b1;
    end else if (state_reg == ST_IDLE) begin
      // First phase after IDLE has unknown history, so its length is not judged
      state_next   = pat_state;
      dwell_next   = {{(CNT_W-1){1'b0}}, 1'b1};
      pc_next      = 1'b1;
      partial_next = 1'b1;
    end else if (pat_state != state_reg) begin
      if (!partial_reg && (dwell_reg < min_dwell))
        err_set[E_SHORT] = 1'b1;
      if (pat_state != succ_state)
        err_set[E_ORDER] = 1'b1;
      else if (state_reg == ST_YELLOW)
        cycle_next = cycle_reg + 16'd1;
      state_next   = pat_state;
      dwell_next   = {{(CNT_W-1){1'b0}}, 1'b1};
      pc_next      = 1'b1;
      partial_next = 1'b0;
    end else if (dwell_reg != DWELL_SAT) begin
      dwell_next = dwell_inc;
      if (dwell_inc == DWELL_MAX)
        err_set[E_TIMEOUT] = 1'b1;
    end
  end

  // Sticky flags: clear wins over history, a fresh error wins over clear
  for (genvar gi = 0; gi < 4; gi++) begin : g_err
    assign err_next[gi] = (mon.clr_err ? 1'b0 : err_reg[gi]) | err_set[gi];
  end

  // State and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      dwell_reg   <= '0;
      pc_reg      <= 1'b0;
      partial_reg <= 1'b0;
      cycle_reg   <= '0;
      err_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      dwell_reg   <= dwell_next;
      pc_reg      <= pc_next;
      partial_reg <= partial_next;
      cycle_reg   <= cycle_next;
      err_reg     <= err_next;
    end
  end

  assign mon.phase        = state_reg;
  assign mon.phase_change = pc_reg;
  assign mon.dwell_cnt    = dwell_reg;
  assign mon.cycle_cnt    = cycle_reg;
  assign mon.err_illegal  = err_reg[E_ILLEGAL];
  assign mon.err_order    = err_reg[E_ORDER];
  assign mon.err_short    = err_reg[E_SHORT];
  assign mon.err_timeout  = err_reg[E_TIMEOUT];

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Downstream checker for the traffic-light controller. Samples the controller's 3-bit `lights` bus every clock and decodes it into a phase. Times how long each phase lasts, checks the phase order and dwell limits, and raises sticky error flags. Also counts completed light cycles, so the bench and the status logic can confirm controller health without re-deriving the FSM.

## Interface
- `CNT_W`, 8: width of the dwell counter, which saturates at 2^CNT_W−1.
- `MIN_RED`, 4: minimum legal red dwell, in cycles.
- `MIN_GREEN`, 4: minimum legal green dwell, in cycles.
- `MIN_YELLOW`, 2: minimum legal yellow dwell, in cycles.
- `MAX_DWELL`, 200: dwell count at which a phase is declared stuck. Must be ≤ 2^CNT_W−1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `lights`  in  3  controller output. [2]=red, [1]=yellow, [0]=green; exactly one bit set is legal.
- `clr_err`  in  1  synchronous clear of all sticky error flags.
- `phase`  out  2  decoded phase: 00 IDLE, 01 RED, 10 GREEN, 11 YELLOW.
- `phase_change`  out  1  one-cycle pulse on the cycle `phase` takes a new value.
- `dwell_cnt`  out  CNT_W  cycles spent in the current phase (1 on the entry cycle).
- `cycle_cnt`  out  16  count of completed RED→GREEN→YELLOW→RED cycles; wraps at 65535→0.
- `err_illegal`  out  1  sticky flag: a pattern other than 100/010/001 was seen.
- `err_order`  out  1  sticky flag: a transition other than R→G, G→Y or Y→R occurred.
- `err_short`  out  1  sticky flag: a phase was left before its minimum dwell.
- `err_timeout`  out  1  sticky flag: `dwell_cnt` reached MAX_DWELL.

## Operation
- **State machine.** States are IDLE, RED, GREEN and YELLOW; `phase` is the state register itself.
- **Legal input patterns.** 100 means RED, 010 means GREEN-less YELLOW (yellow), 001 means GREEN.
- **IDLE exit.** From IDLE, the first legal pattern enters its phase directly, with no order check and no short check.
  - This "first phase" is marked partial; its departure skips the short check.
- **Phase change.** In any non-IDLE state, a legal pattern different from the current phase causes a transition.
  - `dwell_cnt` is loaded with 1 and `phase_change` pulses.
  - `err_short` is set if the departing dwell_cnt < MIN of the departing phase, unless that phase is partial.
  - `err_order` is set if the transition is not R→G, G→Y or Y→R. The new phase is still entered.
  - A legal Y→R transition increments `cycle_cnt`.
- **Same pattern.** `dwell_cnt` increments, saturating at 2^CNT_W−1.
  - When `dwell_cnt` becomes equal to MAX_DWELL, `err_timeout` is set.
- **Illegal pattern.** An illegal pattern (000, 011, 101, 110 or 111) in any state has the following effects:
  - `err_illegal` is set.
  - The state goes to IDLE and `dwell_cnt` becomes 0.
  - `phase_change` pulses only if the state was not already IDLE.
  - No short or order check is performed.
- **Flag behaviour.** Error flags stay set until `clr_err` or `rst`.
  - If `clr_err` and a new error condition occur in the same cycle, the new condition's flag ends set; other flags clear.
- **Counter scope.** `cycle_cnt` is not affected by `clr_err`.

## Timing
- **Reset values.** While `rst` is high (asynchronous):
  - `phase`=00, `dwell_cnt`=0, `cycle_cnt`=0, `phase_change`=0.
  - All `err_*`=0 and the partial marker is cleared.
- **Latency.** All outputs are registered. A `lights` value present before rising edge k is reflected in every output immediately after edge k, i.e. one cycle of latency.
- **Pulse width.** `phase_change` is high for exactly one cycle per transition. Back-to-back changes on consecutive cycles give consecutive pulses.
- **Reset mid-operation.** Asserting `rst` mid-phase returns all state to IDLE with no error set. The next legal pattern is treated as a partial first phase.
- **No input handshake.** `lights` is sampled every cycle; the monitor never stalls the controller.

## Test plan
- **Reset release:** assert `rst`, then release with `lights`=100 held.
  - Expect `phase`=01 and `dwell_cnt`=1 one edge after release, and `phase_change`=1 for that cycle.
  - Expect all `err_*`=0.
- **Nominal cycle:** drive R for 6 cycles, G for 5, Y for 3, then back to R.
  - Expect `cycle_cnt` 0→1 on the Y→R edge and `dwell_cnt` sequence 1..6, 1..5, 1..3, 1.
  - Expect no error flags.
- **Order violation:** from RED with dwell 5, drive 010 (yellow).
  - Expect `err_order`=1 and `phase`=11, and `cycle_cnt` unchanged.
  - Assert `clr_err` for one cycle and expect `err_order`=0 afterwards.
- **Short phase:** after a full RED, drive G for 2 cycles, then Y.
  - Expect `err_short`=1 on the G→Y edge and `err_order`=0.
- **Illegal and stuck:**
  - Drive 110 mid-GREEN: expect `err_illegal`=1, `phase`=00, `dwell_cnt`=0 and a `phase_change` pulse.
  - Then hold 100 for 205 cycles: expect `err_timeout` to rise when `dwell_cnt`=200, with `dwell_cnt` continuing to 205.
- **Saturation and simultaneous events:**
  - With CNT_W=4 and MAX_DWELL=15, hold RED 20 cycles: expect `dwell_cnt` to saturate at 15.
  - Assert `clr_err` on the same edge as an illegal 000: expect `err_illegal`=1 and `err_timeout`=0 after the edge.
